ie_opa_stage: RTL and testbench

- Registered operand-A select stage between decode and the ALU in the pipelined core.
- Generalises the single-cycle rs1/PC operand mux:
  - parametrised data and address widths
  - four select modes
  - EX/MEM result forwarding
  - valid/ready pipeline handshake with flush
  - saturating forward-event counter
- Output feeds the ALU input register directly.

---
 rtl/ie_opa_stage.sv | 150 +++++++++++++++
 tb/tb_ie_opa_stage.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ie_opa_stage.sv
// ie_opa_stage: registered operand-A select (rs1 / PC / zero / PC+4) with valid/ready handshake.
// Define IE_OPA_FWD_EN to enable EX/MEM forwarding and the saturating forward-event counter.
module ie_opa_stage #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 11,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        sel,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [XLEN-1:0]   rs1_value,
    input  logic [ADDR_W-1:0] pc,
    input  logic              ex_wr_en,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [XLEN-1:0]   ex_result,
    input  logic              mem_wr_en,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [XLEN-1:0]   mem_result,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   opa,
    output logic [1:0]        fwd_src,
    output logic [CNT_W-1:0]  fwd_count,
    input  logic              clr_count
);
    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    logic              r_state;
    logic              w_state_nxt;
    logic              w_xfer;
    logic              w_ex_hit;
    logic              w_mem_hit;
    logic [XLEN-1:0]   w_pc_ext;
    logic [XLEN-1:0]   w_sel_val;
    logic [1:0]        w_sel_src;
    logic [XLEN-1:0]   r_opa;
    logic [1:0]        r_fwd_src;

    assign w_pc_ext = XLEN'(pc);
    assign in_ready = (r_state == ST_EMPTY) || out_ready;
    // A flush suppresses capture even though in_ready still reports acceptance.
    assign w_xfer   = in_valid && in_ready && !flush;

`ifdef IE_OPA_FWD_EN
    assign w_ex_hit  = ex_wr_en  && (ex_rd  == rs1_addr) && (rs1_addr != {REG_AW{1'b0}});
    assign w_mem_hit = mem_wr_en && (mem_rd == rs1_addr) && (rs1_addr != {REG_AW{1'b0}});
`else
    logic w_unused_fwd;
    assign w_ex_hit     = 1'b0;
    assign w_mem_hit    = 1'b0;
    assign w_unused_fwd = ^{ex_wr_en, ex_rd, ex_result, mem_wr_en, mem_rd, mem_result,
                            clr_count, rs1_addr};
`endif

    // Operand select with EX-over-MEM forwarding priority
    always_comb begin
        w_sel_val = {XLEN{1'b0}};
        w_sel_src = 2'd0;
        case (sel)
            2'd0: begin
                if (w_ex_hit) begin
                    w_sel_val = ex_result;
                    w_sel_src = 2'd1;
                end else if (w_mem_hit) begin
                    w_sel_val = mem_result;
                    w_sel_src = 2'd2;
                end else begin
                    w_sel_val = rs1_value;
                    w_sel_src = 2'd0;
                end
            end
            2'd1:    w_sel_val = w_pc_ext;
            2'd2:    w_sel_val = {XLEN{1'b0}};
            2'd3:    w_sel_val = w_pc_ext + XLEN'(32'd4);
            default: w_sel_val = {XLEN{1'b0}};
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; flush dominates every handshake event
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_xfer) w_state_nxt = ST_FULL;
                else        w_state_nxt = ST_EMPTY;
            end
            ST_FULL: begin
                if (flush)          w_state_nxt = ST_EMPTY;
                else if (w_xfer)    w_state_nxt = ST_FULL;
                else if (out_ready) w_state_nxt = ST_EMPTY;
                else                w_state_nxt = ST_FULL;
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Output decode from the state register
    always_comb begin
        out_valid = (r_state == ST_FULL);
    end

    // Operand and forward-source registers; hold unless a transfer occurs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opa     <= {XLEN{1'b0}};
            r_fwd_src <= 2'd0;
        end else if (w_xfer) begin
            r_opa     <= w_sel_val;
            r_fwd_src <= w_sel_src;
        end
    end

    assign opa     = r_opa;
    assign fwd_src = r_fwd_src;

`ifdef IE_OPA_FWD_EN
    logic [CNT_W-1:0] r_fwd_count;

    // Saturating forward-event counter; clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fwd_count <= {CNT_W{1'b0}};
        end else if (clr_count) begin
            r_fwd_count <= {CNT_W{1'b0}};
        end else if (w_xfer && (w_sel_src != 2'd0) && (r_fwd_count != {CNT_W{1'b1}})) begin
            r_fwd_count <= r_fwd_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign fwd_count = r_fwd_count;
`else
    assign fwd_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_ie_opa_stage.sv
// Randomised self-checking bench for ie_opa_stage against a cycle-level reference model.
module tb_ie_opa_stage;
    localparam int XLEN = 32, ADDR_W = 11, REG_AW = 5, CNT_W = 2;
`ifdef IE_OPA_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [1:0] sel = 2'd0, fwd_src;
    logic [REG_AW-1:0] rs1_addr = '0, ex_rd = '0, mem_rd = '0;
    logic [XLEN-1:0] rs1_value = '0, ex_result = '0, mem_result = '0, opa;
    logic [ADDR_W-1:0] pc = '0;
    logic ex_wr_en = 1'b0, mem_wr_en = 1'b0, flush = 1'b0, clr_count = 1'b0;
    logic [CNT_W-1:0] fwd_count;

    int n_checks = 0, n_errors = 0;

    // model state
    bit m_valid = 1'b0;
    logic [XLEN-1:0] m_opa = '0;
    int m_src = 0, m_cnt = 0;
    int cnt_max = (1 << CNT_W) - 1;

    ie_opa_stage #(.XLEN(XLEN), .ADDR_W(ADDR_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
        .rs1_addr(rs1_addr), .rs1_value(rs1_value), .pc(pc), .ex_wr_en(ex_wr_en),
        .ex_rd(ex_rd), .ex_result(ex_result), .mem_wr_en(mem_wr_en), .mem_rd(mem_rd),
        .mem_result(mem_result), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .opa(opa), .fwd_src(fwd_src), .fwd_count(fwd_count), .clr_count(clr_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check_eq({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
        check_eq({tag, ".opa"}, 64'(opa), 64'(m_opa));
        check_eq({tag, ".fwd_src"}, 64'(fwd_src), 64'(m_src));
        check_eq({tag, ".fwd_count"}, 64'(fwd_count), 64'(m_cnt));
    endtask

    // One clock: check in_ready mid-cycle, predict from the rules, then compare after the edge.
    task automatic step(input string tag);
        bit exp_ready, xfer;
        logic [XLEN-1:0] val;
        int src;
        #2;
        exp_ready = !m_valid || out_ready;
        check_eq({tag, ".in_ready"}, 64'(in_ready), 64'(exp_ready));
        xfer = in_valid && exp_ready && !flush;
        src = 0;
        case (sel)
            2'd1: val = {{(XLEN-ADDR_W){1'b0}}, pc};
            2'd2: val = '0;
            2'd3: val = {{(XLEN-ADDR_W){1'b0}}, pc} + 32'd4;
            default: begin
                val = rs1_value;
                if (FWD && rs1_addr != 0) begin
                    if (ex_wr_en && ex_rd == rs1_addr) begin
                        val = ex_result; src = 1;
                    end else if (mem_wr_en && mem_rd == rs1_addr) begin
                        val = mem_result; src = 2;
                    end
                end
            end
        endcase
        @(posedge clk);
        #1;
        if (flush) m_valid = 1'b0;
        else if (xfer) begin
            m_valid = 1'b1; m_opa = val; m_src = src;
        end else if (out_ready) m_valid = 1'b0;
        if (FWD) begin
            if (clr_count) m_cnt = 0;
            else if (xfer && src != 0 && m_cnt < cnt_max) m_cnt++;
        end
        check_model(tag);
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_opa = '0; m_src = 0; m_cnt = 0;
    endtask

    task automatic set_fwd(input logic [4:0] ra, input logic exw, input logic [4:0] exd,
                           input logic memw, input logic [4:0] memd);
        rs1_addr = ra; ex_wr_en = exw; ex_rd = exd; mem_wr_en = memw; mem_rd = memd;
    endtask

    initial begin
        #12;
        check_model("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // PC select, max address
        in_valid = 1'b1; out_ready = 1'b1; sel = 2'd1; pc = 11'h7FF;
        step("pc_sel");
        check_eq("pc_sel.const", 64'(opa), 64'h7FF);

        // EX forward beats MEM forward
        sel = 2'd0; rs1_value = 32'h11; ex_result = 32'hAA; mem_result = 32'hBB;
        set_fwd(5'd5, 1'b1, 5'd5, 1'b1, 5'd5);
        step("fwd_ex");
`ifdef IE_OPA_FWD_EN
        check_eq("fwd_ex.const", 64'(opa), 64'hAA);
`endif
        ex_wr_en = 1'b0;
        step("fwd_mem");
`ifdef IE_OPA_FWD_EN
        check_eq("fwd_mem.cnt", 64'(fwd_count), 64'd2);
`endif

        // x0 never forwards
        set_fwd(5'd0, 1'b1, 5'd0, 1'b0, 5'd0); ex_result = 32'hFF; rs1_value = '0;
        step("x0");

        // stall: load 0x1234, then hold for 3 cycles
        set_fwd(5'd6, 1'b0, 5'd0, 1'b0, 5'd0); rs1_value = 32'h1234;
        step("stall_load");
        out_ready = 1'b0; rs1_value = 32'h5678;
        for (int i = 0; i < 3; i++) step("stall_hold");
        check_eq("stall.const", 64'(opa), 64'h1234);
        out_ready = 1'b1;
        step("stall_release");
        check_eq("stall_release.const", 64'(opa), 64'h5678);

        // flush with a forwarded transfer pending
        set_fwd(5'd3, 1'b1, 5'd3, 1'b0, 5'd0); flush = 1'b1;
        step("flush");
        check_eq("flush.valid", 64'(out_valid), 64'd0);
        flush = 1'b0;

        // PC+4
        sel = 2'd3; pc = 11'h7FC;
        step("pc4");
        check_eq("pc4.const", 64'(opa), 64'h800);

        // saturation then clear coincident with forwarded transfer
        sel = 2'd0;
        for (int i = 0; i < 5; i++) step("sat");
`ifdef IE_OPA_FWD_EN
        check_eq("sat.const", 64'(fwd_count), 64'd3);
`endif
        clr_count = 1'b1;
        step("clr");
        check_eq("clr.const", 64'(fwd_count), 64'd0);
        clr_count = 1'b0;

        // asynchronous reset mid-operation
        step("pre_rst");
        rst_n = 1'b0; #2;
        model_reset();
        check_model("async_rst");
        rst_n = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;

        // randomised traffic
        for (int i = 0; i < 400; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            sel        = 2'($urandom_range(0, 3));
            rs1_addr   = 5'($urandom_range(0, 3));
            rs1_value  = $urandom;
            pc         = 11'($urandom);
            ex_wr_en   = 1'($urandom);
            ex_rd      = 5'($urandom_range(0, 3));
            ex_result  = $urandom;
            mem_wr_en  = 1'($urandom);
            mem_rd     = 5'($urandom_range(0, 3));
            mem_result = $urandom;
            flush      = ($urandom_range(0, 15) == 0);
            clr_count  = ($urandom_range(0, 31) == 0);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
